// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS instruction-fetch path: fault/idle filler word,
// loader state encoding and byte-to-word address helper.
package mips_pkg;

  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  function automatic logic [29:0] word_addr(input logic [31:0] byte_addr);
    return byte_addr[31:2];
  endfunction

endpackage

// File: rtl/inst_ram.sv
// Synchronous instruction RAM: one write port, one registered read port with enable.
// The array and the read register are deliberately not reset.
module inst_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Write port and registered read; rdata holds while re is low.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/inst_mem_loadable.sv
// Loadable instruction memory: host streams a program over valid/ready, core fetches
// with one-cycle latency; faulting or non-RUN fetches return NOP_WORD.
module inst_mem_loadable
  import mips_pkg::*;
#(
  parameter int                 DATA_W   = 32,
  parameter int                 DEPTH    = 64,
  parameter logic [DATA_W-1:0]  NOP_WORD = DATA_W'(NOP_WORD_DEFAULT)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load_start,
  input  logic                       load_valid,
  input  logic [DATA_W-1:0]          load_data,
  input  logic                       load_last,
  output logic                       load_ready,
  output logic                       load_done,
  output logic [$clog2(DEPTH):0]     load_count,
  output logic                       load_overflow,
  input  logic                       fetch_req,
  input  logic [31:0]                fetch_addr,
  output logic [DATA_W-1:0]          inst,
  output logic                       inst_valid,
  output logic                       fault_misaligned,
  output logic                       fault_range
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  state_e          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            done_q, done_d;
  logic            ready_q, ready_d;
  logic            valid_q, valid_d;
  logic            fmis_q, fmis_d;
  logic            frng_q, frng_d;
  logic            use_ram_q, use_ram_d;

  logic [29:0]       wa_s;
  logic              mis_s, rng_s, run_fetch_s, accept_s, last_slot_s, re_s;
  logic [DATA_W-1:0] ram_rdata_s;

  // Address decode and handshake qualification; load_start pre-empts both a word and a fetch.
  always_comb begin
    wa_s        = word_addr(fetch_addr);
    mis_s       = (fetch_addr[1:0] != 2'b00);
    rng_s       = (wa_s >= 30'(DEPTH));
    run_fetch_s = fetch_req && (state_q == RUN) && !load_start;
    accept_s    = load_valid && (state_q == LOAD) && !load_start;
    last_slot_s = (ptr_q == AW'(DEPTH - 1));
    re_s        = run_fetch_s && !mis_s && !rng_s;
  end

  // Loader FSM: next state, pointer, word count, overflow and done pulse.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE, RUN: begin
        if (load_start) begin
          state_d    = LOAD;
          ptr_d      = '0;
          count_d    = '0;
          overflow_d = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      LOAD: begin
        if (load_start) begin
          state_d    = LOAD;
          ptr_d      = '0;
          count_d    = '0;
          overflow_d = 1'b0;
        end else if (accept_s) begin
          ptr_d   = ptr_q + AW'(1);
          count_d = count_q + CW'(1);
          if (load_last || last_slot_s) begin
            state_d    = RUN;
            done_d     = 1'b1;
            overflow_d = !load_last;
          end else begin
            state_d = LOAD;
          end
        end else begin
          state_d = LOAD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ready_d = (state_d == LOAD);
  end

  // Fetch response: faults and RAM select update only on a request, otherwise hold.
  always_comb begin
    valid_d   = fetch_req;
    fmis_d    = fmis_q;
    frng_d    = frng_q;
    use_ram_d = use_ram_q;
    if (fetch_req) begin
      if (run_fetch_s) begin
        fmis_d    = mis_s;
        frng_d    = rng_s;
        use_ram_d = !mis_s && !rng_s;
      end else begin
        fmis_d    = 1'b0;
        frng_d    = 1'b0;
        use_ram_d = 1'b0;
      end
    end else begin
      use_ram_d = use_ram_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b0;
      valid_q    <= 1'b0;
      fmis_q     <= 1'b0;
      frng_q     <= 1'b0;
      use_ram_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
      valid_q    <= valid_d;
      fmis_q     <= fmis_d;
      frng_q     <= frng_d;
      use_ram_q  <= use_ram_d;
    end
  end

  inst_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .we    (accept_s),
    .waddr (ptr_q),
    .wdata (load_data),
    .re    (re_s),
    .raddr (wa_s[AW-1:0]),
    .rdata (ram_rdata_s)
  );

  assign load_ready       = ready_q;
  assign load_done        = done_q;
  assign load_count       = count_q;
  assign load_overflow    = overflow_q;
  assign inst_valid       = valid_q;
  assign fault_misaligned = fmis_q;
  assign fault_range      = frng_q;
  assign inst             = use_ram_q ? ram_rdata_s : NOP_WORD;

endmodule

// File: doc/inst_mem_loadable.md
# inst_mem_loadable

Parametrised, loadable instruction memory for the single-cycle MIPS core, replacing the fixed combinational program ROM. A boot/test host streams a program into word addresses 0..N-1 over a valid/ready load port. The core then fetches instructions through a registered, one-cycle-latency read port. Misaligned or out-of-range fetches return NOP (0x00000000) and raise a fault flag instead of silently aliasing.

## Interface
Parameters:
- DATA_W, 32, instruction width in bits
- DEPTH, 64, number of instruction words (power of two, ≥ 2)
- NOP_WORD, 32'h00000000, value returned on fault, idle or load

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- load_start  in  1  one-cycle pulse; enter LOAD, pointer ← 0
- load_valid  in  1  load word present
- load_data  in  DATA_W  word to write at the current pointer
- load_last  in  1  qualifies the final load word
- load_ready  out  1  block accepts a load word this cycle
- load_done  out  1  one-cycle pulse when loading finishes
- load_count  out  $clog2(DEPTH)+1  words written by the last/ongoing load
- load_overflow  out  1  sticky; DEPTH reached without load_last
- fetch_req  in  1  fetch request
- fetch_addr  in  32  byte address
- inst  out  DATA_W  fetched instruction
- inst_valid  out  1  inst is valid (response to fetch_req of the previous cycle)
- fault_misaligned  out  1  qualifies inst; fetch_addr[1:0] ≠ 0
- fault_range  out  1  qualifies inst; fetch_addr[31:2] ≥ DEPTH

## Operation
- States: IDLE (post-reset, nothing loaded), LOAD, RUN.
- IDLE → LOAD on load_start. RUN → LOAD on load_start. LOAD → LOAD on load_start restarts: pointer ← 0, load_count ← 0, load_overflow ← 0.
- load_ready = (state == LOAD). A word is accepted when load_valid && load_ready. On acceptance: mem[ptr] ← load_data, ptr++, load_count++.
- LOAD → RUN when the accepted word has load_last, or when the accepted word has ptr == DEPTH-1. In the DEPTH-1 case without load_last, load_overflow ← 1. Either exit pulses load_done in the following cycle.
- Fetch in RUN:
  - word index = fetch_addr[$clog2(DEPTH)+1:2].
  - misaligned has priority; both fault flags may be set together.
  - On any fault, inst = NOP_WORD.
- Fetch in IDLE or LOAD: inst_valid still asserted, inst = NOP_WORD, no fault flags. The core stalls on NOPs and never hangs.
- Words beyond load_count are not cleared; reading them returns stale contents. This is legal, not a fault.
- Memory array is not reset.

## Timing
- Reset values: state IDLE, load_ready 0, load_done 0, load_count 0, load_overflow 0, inst NOP_WORD, inst_valid 0, both faults 0.
- Fetch latency is exactly 1 cycle. One fetch per cycle, back-to-back, no bubbles. inst, inst_valid and the faults are registered and hold their value when fetch_req = 0 (with inst_valid = 0).
- A write accepted in cycle t is readable by a fetch issued in cycle t+1 or later (after the return to RUN).
- load_start and fetch_req in the same cycle while in RUN: load_start wins, and that fetch returns NOP_WORD.
- load_start together with load_valid: the restart applies and the word is not written.
- load_done is asserted for exactly one cycle. load_count is stable from load_done until the next load_start.
- rst_n asserted mid-load: the load is abandoned immediately, the block is in IDLE, and all outputs take their reset values.

## Structure
- Shared package mips_pkg: NOP_WORD default constant, state enum {IDLE, LOAD, RUN}, and the word-address helper function.
- Sub-module inst_ram: single-port-write / single-port-read synchronous RAM, DEPTH × DATA_W, registered read, no reset on the array.
- Top level: FSM, load pointer/counter, address decode and fault logic, output registers.

## Test plan
- Load 0xAC000064, 0x8C070064, 0x00E13820 with load_last on the third word, then fetch addresses 0, 4, 8 back-to-back → inst 0xAC000064, 0x8C070064, 0x00E13820 on consecutive cycles each one cycle later; load_done pulses once; load_count = 3.
- After that load, fetch 0x6 → inst 0, fault_misaligned = 1; fetch 0x100 with DEPTH = 64 → inst 0, fault_range = 1; fetch 0x102 → both faults set.
- DEPTH = 4: stream 5 words without load_last → load_ready drops after the 4th, state RUN, load_overflow = 1, load_count = 4; fetch 0xC returns the 4th word.
- Fetch 0x0 in IDLE and during LOAD → inst_valid = 1, inst = 0, no faults.
- Assert rst_n low after 2 accepted load words → outputs at reset values and load_ready = 0; then load_start with 1 word plus load_last → load_count = 1.
- In RUN, load_start and fetch_req to address 4 in the same cycle → NOP returned, load_ready = 1 the next cycle.
